wb_spi_fanout_bridge: RTL
=========================

# wb_spi_fanout_bridge

Parametrised Wishbone bridge between the single 8-bit Wishbone master port of `i2c_to_wb_top` and N_CH `simple_spi_top` slave instances. It gives each slave its own address window and per-channel `cyc`/`stb`. It adds a bus timeout, error and retry signalling, channel quarantine after a timeout, and a local register bank that aggregates and masks the SPI interrupts.

## Interface
- `N_CH`, 2: number of SPI channels (1..7).
- `ADDR_W`, 8: master address width.
- `CH_ADDR_W`, 3: per-slave local address width. Channel index = `m_adr_i[ADDR_W-1:CH_ADDR_W]`.
- `TIMEOUT`, 255: maximum cycles to wait for a slave ack (≥1).

Ports (reset values in Operation):
- `wb_clk_i  in  1`  bridge clock. Same clock drives the SPI cores.
- `wb_rst_i  in  1`  reset. Asynchronous, active-high.
- `m_cyc_i, m_stb_i, m_we_i  in  1 each`  master cycle, strobe, write enable.
- `m_adr_i  in  ADDR_W`  master address.
- `m_dat_i  in  8`  master write data.
- `m_dat_o  out  8`  read data to master.
- `m_ack_o, m_err_o, m_rty_o  out  1 each`  master termination.
- `s_cyc_o, s_stb_o  out  N_CH each`  per-channel cycle and strobe, one-hot or zero.
- `s_we_o  out  1`  shared write enable to slaves.
- `s_adr_o  out  CH_ADDR_W`  shared slave address.
- `s_dat_o  out  8`  shared write data to slaves.
- `s_dat_i  in  8*N_CH`  slave read data. Channel c is at `[8c+7:8c]`.
- `s_ack_i, s_inta_i  in  N_CH each`  slave acks and interrupts.
- `inta_o  out  1`  aggregated masked interrupt.

## Operation
- **Address decode** (channel index `ch`):
  - `ch < N_CH`: slave channel.
  - `ch == 2^(ADDR_W-CH_ADDR_W)-1`: local bank.
  - anything else: invalid.
- **Local bank:**
  - offset 0 `IRQ_STAT`: read-only, `s_inta_i`.
  - offset 1 `IRQ_MASK`: read/write.
  - offset 2 `TO_FLAG`: sticky per-channel timeout flags, write-1-to-clear.
  - Unused bits read 0. Other offsets: read 0, writes ignored, still acked.
- **FSM states:** IDLE, ACCESS, RESP, DRAIN.
  - **IDLE:** on `m_cyc_i & m_stb_i`, latch `adr`/`dat`/`we` and decode.
    - Local: perform the access, then RESP(ack).
    - Invalid: RESP(err).
    - Channel with `TO_FLAG[ch]` set: RESP(rty), no slave access.
    - Otherwise: ACCESS, counter cleared.
  - **ACCESS:** drive `s_cyc_o[ch]` and `s_stb_o[ch]` with the latched `we`/`adr`/`dat`. The counter increments each cycle.
    - `s_ack_i[ch]`: capture `s_dat_i` for reads, then RESP(ack).
    - Counter == `TIMEOUT` without ack: set `TO_FLAG[ch]`, then RESP(err).
    - Ack and expiry on the same cycle: ack wins, flag not set.
    - `m_cyc_i` low: abort to IDLE. No response, no flag.
  - **RESP:** exactly one of `ack`/`err`/`rty` is high for exactly 1 cycle. Slave strobes are low. Next state is DRAIN.
  - **DRAIN:** wait until `m_stb_i` or `m_cyc_i` is low, then IDLE. This prevents re-executing a request the master has not yet dropped.
- **`m_dat_o`:** updated only on read acks (slave or local). Otherwise it holds its value.
- **`inta_o`:** registered `|(s_inta_i & IRQ_MASK)`.
- **Reset:** forces the following, asynchronously:
  - all outputs to 0;
  - `IRQ_MASK` and `TO_FLAG` to 0;
  - FSM to IDLE.
  - A slave cycle in progress is dropped with no response.

## Timing
- All outputs are registered.
- **Local access:** request sampled at cycle 0, `m_ack_o` at cycle 1.
- **Slave access:** request sampled at cycle 0, `s_stb_o` high at cycle 1.
  - Slave ack sampled at cycle k gives `m_ack_o` at cycle k+1.
  - With `simple_spi_top` (registered ack), `m_ack_o` is at cycle 3.
- **Timeout:** stb is high for exactly `TIMEOUT` cycles. `m_err_o` follows at cycle `TIMEOUT`+2.
- **Turnaround:** minimum 1 cycle in DRAIN between consecutive requests.
- **`inta_o`:** 1-cycle latency from `s_inta_i`.
- **Arithmetic:** counter width is `$clog2(TIMEOUT+1)`. It saturates and never wraps.

## Structure
- **Package `wb_spi_bridge_pkg`:**
  - FSM state enum;
  - local offsets `IRQ_STAT=0`, `IRQ_MASK=1`, `TO_FLAG=2`;
  - a function computing the local-bank channel index from the widths.
- **Sub-module `wb_bridge_regs`:** local register bank, interrupt masking and timeout flags.
  - Inputs: write strobe, offset, data, flag-set vector.
  - Outputs: read data and `inta_o`.

## Test plan
- **Slave write then read, channel 1** (`ADDR_W`=8, `CH_ADDR_W`=3): write `0x5A` at address `0x09`, then read it back.
  - `s_stb_o` = `2'b10` and `s_adr_o` = 1.
  - `m_ack_o` at cycle 3 with no err/rty.
  - Read returns `0x5A` on `m_dat_o`.
- **Timeout** (`TIMEOUT`=4): access channel 0 with the slave never acking.
  - stb is high for 4 cycles, then `m_err_o` pulses.
  - Local read of `0xFA` returns `0x01`.
  - A following access to channel 0 gets `m_rty_o`, with `s_stb_o` staying 0.
- **Clear quarantine:** write `0x01` to `0xFA`.
  - `TO_FLAG` reads 0.
  - The next channel 0 access is acked normally.
- **Interrupts and invalid address:** drive `s_inta_i` = `2'b11` with mask `0x02`.
  - `inta_o` = 1; clearing the mask drops it 1 cycle later.
  - Accessing address `0x20` (ch 4) gives `m_err_o`.
- **Abort, hold and reset:**
  - Drop `m_cyc_i` mid-ACCESS: `s_stb_o` = 0 next cycle and no response.
  - Hold `m_stb_i` high 3 cycles after ack: exactly one ack.
  - Assert `wb_rst_i` mid-access: all outputs 0 immediately.

Source files
------------

// File: rtl/wb_spi_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-SPI fanout bridge.
package wb_spi_bridge_pkg;

    // Bridge transaction FSM.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_DRAIN  = 2'd3
    } bridge_state_t;

    // Local register bank offsets.
    localparam int unsigned IRQ_STAT = 0;
    localparam int unsigned IRQ_MASK = 1;
    localparam int unsigned TO_FLAG  = 2;

    // The local bank sits at the all-ones channel index.
    function automatic int unsigned local_ch_idx(input int unsigned addr_w,
                                                 input int unsigned ch_addr_w);
        return (32'd1 << (addr_w - ch_addr_w)) - 32'd1;
    endfunction

endpackage

// File: rtl/wb_bridge_regs.sv
// Local register bank: interrupt status/mask, sticky per-channel timeout flags.
module wb_bridge_regs
    import wb_spi_bridge_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int OFF_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [OFF_W-1:0] off,
    input  logic [7:0]       wdat,
    input  logic [N_CH-1:0]  flag_set,
    input  logic [N_CH-1:0]  irq_in,
    output logic [7:0]       rdat,
    output logic [N_CH-1:0]  to_flag,
    output logic             inta_o
);

    logic [N_CH-1:0] irq_mask;
    logic [N_CH-1:0] flag_clr;

    // Write-1-to-clear vector for the timeout flags.
    always_comb begin
        flag_clr = '0;
        if (wr_en && off == OFF_W'(TO_FLAG))
            flag_clr = wdat[N_CH-1:0];
    end

    // Mask register, sticky flags (a set beats a clear) and registered interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_mask <= '0;
            to_flag  <= '0;
            inta_o   <= 1'b0;
        end else begin
            if (wr_en && off == OFF_W'(IRQ_MASK))
                irq_mask <= wdat[N_CH-1:0];
            to_flag <= (to_flag & ~flag_clr) | flag_set;
            inta_o  <= |(irq_in & irq_mask);
        end
    end

    // Read mux; unused bits and unmapped offsets read as zero.
    always_comb begin
        rdat = 8'h00;
        case (off)
            OFF_W'(IRQ_STAT): rdat = 8'(irq_in);
            OFF_W'(IRQ_MASK): rdat = 8'(irq_mask);
            OFF_W'(TO_FLAG):  rdat = 8'(to_flag);
            default:          rdat = 8'h00;
        endcase
    end

endmodule

// File: rtl/wb_spi_fanout_bridge.sv
// Wishbone master to N_CH SPI slave fanout with timeout, quarantine and local IRQ bank.
module wb_spi_fanout_bridge
    import wb_spi_bridge_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int ADDR_W    = 8,
    parameter int CH_ADDR_W = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 m_cyc_i,
    input  logic                 m_stb_i,
    input  logic                 m_we_i,
    input  logic [ADDR_W-1:0]    m_adr_i,
    input  logic [7:0]           m_dat_i,
    output logic [7:0]           m_dat_o,
    output logic                 m_ack_o,
    output logic                 m_err_o,
    output logic                 m_rty_o,
    output logic [N_CH-1:0]      s_cyc_o,
    output logic [N_CH-1:0]      s_stb_o,
    output logic                 s_we_o,
    output logic [CH_ADDR_W-1:0] s_adr_o,
    output logic [7:0]           s_dat_o,
    input  logic [8*N_CH-1:0]    s_dat_i,
    input  logic [N_CH-1:0]      s_ack_i,
    input  logic [N_CH-1:0]      s_inta_i,
    output logic                 inta_o
);

    localparam int CHW   = ADDR_W - CH_ADDR_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CHW-1:0]   LOCAL_CH = CHW'(local_ch_idx(ADDR_W, CH_ADDR_W));
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    bridge_state_t        state_q, state_d;
    logic [N_CH-1:0]      sel_q, sel_d;      // channel owning the current request
    logic [N_CH-1:0]      stb_q, stb_d;      // drives both s_cyc_o and s_stb_o
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 we_q;
    logic [CH_ADDR_W-1:0] adr_q;
    logic [7:0]           dat_q;
    logic                 ack_q, err_q, rty_q;
    logic                 ack_d, err_d, rty_d;
    logic [7:0]           rdat_q, rd_val;
    logic                 rd_ld, lat_en, reg_wr;
    logic [CHW-1:0]       req_ch;
    logic                 req_local;
    logic [N_CH-1:0]      req_oh;
    logic [N_CH-1:0]      flag_set, to_flag;
    logic [7:0]           reg_rdata, slave_rd;

    assign req_ch    = m_adr_i[ADDR_W-1:CH_ADDR_W];
    assign req_local = (req_ch == LOCAL_CH);

    // One-hot slave decode of the incoming address; all-zero means local or invalid.
    always_comb begin
        req_oh = '0;
        for (int c = 0; c < N_CH; c++)
            req_oh[c] = (req_ch == CHW'(c));
    end

    // Read data from whichever slave owns the current request.
    always_comb begin
        slave_rd = 8'h00;
        for (int c = 0; c < N_CH; c++)
            if (sel_q[c])
                slave_rd = slave_rd | s_dat_i[8*c +: 8];
    end

    wb_bridge_regs #(
        .N_CH  (N_CH),
        .OFF_W (CH_ADDR_W)
    ) u_regs (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .wr_en    (reg_wr),
        .off      (m_adr_i[CH_ADDR_W-1:0]),
        .wdat     (m_dat_i),
        .flag_set (flag_set),
        .irq_in   (s_inta_i),
        .rdat     (reg_rdata),
        .to_flag  (to_flag),
        .inta_o   (inta_o)
    );

    // FSM state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state and next values of every registered output.
    // The strobe drops one cycle before expiry is evaluated so that stb is
    // high for exactly TIMEOUT cycles while a late registered ack still wins.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        stb_d    = '0;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rty_d    = 1'b0;
        lat_en   = 1'b0;
        reg_wr   = 1'b0;
        rd_ld    = 1'b0;
        rd_val   = reg_rdata;
        flag_set = '0;
        case (state_q)
            ST_IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    lat_en = 1'b1;
                    sel_d  = req_oh;
                    if (req_local) begin
                        reg_wr  = m_we_i;
                        rd_ld   = !m_we_i;
                        rd_val  = reg_rdata;
                        ack_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (req_oh == '0) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (|(req_oh & to_flag)) begin
                        rty_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = '0;
                        stb_d   = req_oh;
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (!m_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (|(s_ack_i & sel_q)) begin
                    ack_d   = 1'b1;
                    rd_ld   = !we_q;
                    rd_val  = slave_rd;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_MAX) begin
                    err_d    = 1'b1;
                    flag_set = sel_q;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    stb_d = ((cnt_q + CNT_W'(1)) != CNT_MAX) ? sel_q : '0;
                end
            end
            ST_RESP: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!m_stb_i || !m_cyc_i)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sel_q  <= '0;
            stb_q  <= '0;
            cnt_q  <= '0;
            we_q   <= 1'b0;
            adr_q  <= '0;
            dat_q  <= 8'h00;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            rty_q  <= 1'b0;
            rdat_q <= 8'h00;
        end else begin
            sel_q <= sel_d;
            stb_q <= stb_d;
            cnt_q <= cnt_d;
            ack_q <= ack_d;
            err_q <= err_d;
            rty_q <= rty_d;
            if (lat_en) begin
                we_q  <= m_we_i;
                adr_q <= m_adr_i[CH_ADDR_W-1:0];
                dat_q <= m_dat_i;
            end
            if (rd_ld)
                rdat_q <= rd_val;
        end
    end

    assign m_dat_o = rdat_q;
    assign m_ack_o = ack_q;
    assign m_err_o = err_q;
    assign m_rty_o = rty_q;
    assign s_cyc_o = stb_q;
    assign s_stb_o = stb_q;
    assign s_we_o  = we_q;
    assign s_adr_o = adr_q;
    assign s_dat_o = dat_q;

endmodule
